memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, is the maximum number of consecutive data grants issued while an instruction request is pending.
REQ-002 The port list SHALL be exactly as follows (clock and reset first):
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data
- iwait  out  1  instruction stall (1 = not yet complete)
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write data
- dload  out  32  data read data
- dwait  out  1  data stall
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status; values FREE, BUSY, ACCESS, ERROR from cpu_types_pkg
- err  out  1  one-cycle pulse on RAM error

Function
REQ-003 The block SHALL implement a registered FSM with three states: IDLE, IGRANT and DGRANT.
REQ-004 In IDLE, a data request (dREN|dWEN) SHALL transition to DGRANT, unless iREN=1 and streak==STARVE_MAX, in which case it SHALL transition to IGRANT.
REQ-005 In IDLE with only iREN=1, the FSM SHALL transition to IGRANT; with no request, it SHALL remain in IDLE.
REQ-006 In IGRANT, the outputs SHALL be: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-007 In DGRANT, the outputs SHALL be: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
- When dREN and dWEN are both high, the access is a write.
REQ-008 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-009 iwait SHALL be 0 only in IGRANT with ramstate==ACCESS; otherwise iwait SHALL be 1.
REQ-010 dwait SHALL be 0 only in DGRANT with ramstate==ACCESS; otherwise dwait SHALL be 1.
REQ-011 iload and dload SHALL each equal ramload combinationally in every state.
REQ-012 In IGRANT or DGRANT with ramstate==ACCESS, the FSM SHALL return to IDLE on the next edge, giving a mandatory one-cycle bubble between grants.
REQ-013 In IGRANT or DGRANT with ramstate==FREE or BUSY, the FSM SHALL hold the state and all RAM outputs stable.
REQ-014 In IGRANT or DGRANT with ramstate==ERROR, the FSM SHALL return to IDLE, assert err=1 for that cycle, and keep the corresponding wait output at 1; the requester retries.
REQ-015 If a granted request deasserts before ACCESS, the FSM SHALL return to IDLE on the next edge without setting err.
REQ-016 streak SHALL be a 3-bit counter, saturating at STARVE_MAX, with the following updates:
- Entry to DGRANT with iREN=1: increment.
- Entry to DGRANT with iREN=0: clear to 0.
- Entry to IGRANT: clear to 0.
- All other cycles: hold.
REQ-017 From request presentation in IDLE, minimum latency SHALL be two cycles: the grant edge, then the ACCESS cycle with wait=0 when the RAM responds immediately.

Reset
REQ-018 While RST=1 at a rising edge, the block SHALL force state=IDLE and streak=0, regardless of any transfer in progress; the aborted transfer is not completed and err is not pulsed.
REQ-019 Throughout reset, the outputs SHALL be: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, err=0.

Verification
REQ-020 Bench scenario, instruction-only read:
- Stimulus: iREN=1, iaddr=0x100, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF.
- Required: iwait=0 and iload=0xDEADBEEF in the ACCESS cycle; IDLE on the next cycle.
REQ-021 Bench scenario, simultaneous requests:
- Stimulus: iREN=1 and dWEN=1, daddr=0x200, dstore=0x5; single-cycle ACCESS.
- Required: DGRANT first with ramWEN=1, ramaddr=0x200, ramstore=0x5; then bubble; then IGRANT.
REQ-022 Bench scenario, starvation guard:
- Stimulus: dREN and iREN held high continuously, STARVE_MAX=4.
- Required: exactly 4 DGRANTs, then 1 IGRANT, then the pattern repeats.
REQ-023 Bench scenario, RAM error:
- Stimulus: ramstate=ERROR during DGRANT.
- Required: err=1 for one cycle, dwait=1, IDLE next; DGRANT re-issued if dREN is still high.
REQ-024 Bench scenario, reset mid-transfer:
- Stimulus: RST=1 while in IGRANT with ramstate=BUSY.
- Required: ramREN=0 and state=IDLE on the next edge, streak=0, no err pulse.
REQ-025 Bench scenario, read/write conflict:
- Stimulus: dREN=1 and dWEN=1 together.
- Required: ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg : RAM status encoding shared by the arbiter and its users.
//
// memory_arbiter : arbitrates one RAM port between an instruction requester
// and a data requester.
//   - Grants go through a three-state FSM (IDLE / IGRANT / DGRANT).
//   - A mandatory IDLE bubble separates consecutive grants.
//   - Data normally wins a tie. A streak counter counts data grants issued
//     while an instruction request waits. Once it reaches STARVE_MAX, the
//     next tie goes to the instruction side.
//
// Ports
//   CLK, RST             clock; synchronous active-high reset
//   iREN, iaddr          instruction read request / address
//   iload, iwait         instruction read data / stall (1 = not complete)
//   dREN, dWEN           data read / write request (both high = write)
//   daddr, dstore        data address / write data
//   dload, dwait         data read data / stall (1 = not complete)
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   err                  one-cycle pulse when the RAM reports ERROR on a grant
// -----------------------------------------------------------------------------
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module memory_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [DATA_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [DATA_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);
  import cpu_types_pkg::*;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] streak, streak_nxt;
  logic       dreq;
  logic       starved;
  logic       ram_done;

  // Saturating increment of the starvation streak.
  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    if (s >= STARVE_LIM) return STARVE_LIM;
    else                 return s + 3'd1;
  endfunction

  assign dreq     = dREN | dWEN;
  assign starved  = iREN && (streak == STARVE_LIM);
  // ACCESS completes a transfer; ERROR aborts it. Either way the grant ends.
  assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

  // Read data is routed to both requesters unconditionally. The wait flags
  // tell each requester when the data is valid for it.
  assign iload = ramload;
  assign dload = ramload;

  // State / streak register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= 3'd0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Next-state and streak update
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (dreq && !starved) begin
          state_nxt  = DGRANT;
          streak_nxt = iREN ? sat_inc(streak) : 3'd0;
        end else if (iREN) begin
          state_nxt  = IGRANT;
          streak_nxt = 3'd0;
        end
      end
      IGRANT: begin
        // A withdrawn request frees the RAM without flagging an error.
        if (!iREN || ram_done) state_nxt = IDLE;
      end
      DGRANT: begin
        if (!dreq || ram_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM-side and requester-side outputs. While RST is high, all outputs
  // are held at their idle values, even before the reset edge arrives.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    err      = 1'b0;
    if (!RST) begin
      case (state)
        IGRANT: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iwait   = (ramstate != ACCESS);
          err     = iREN && (ramstate == ERROR);
        end
        DGRANT: begin
          // A simultaneous read and write is treated as a write.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dwait    = (ramstate != ACCESS);
          err      = dreq && (ramstate == ERROR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // 0 = no grant, 1 = data grant at 0x400, 2 = instruction grant at 0x100
  function automatic logic [31:0] grant_code();
    if (ramREN && ramaddr == 32'h400) return 32'd1;
    if (ramREN && ramaddr == 32'h100) return 32'd2;
    if (ramREN || ramWEN)             return 32'd3;
    return 32'd0;
  endfunction

  int exp_seq [20] = '{0,1,0,1,0,1,0,1,0,2,0,1,0,1,0,1,0,1,0,2};

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    step(); step();

    // Reset: outputs idle even with a request and ERROR present
    iREN = 1; iaddr = 32'h100; ramstate = ERROR; #1;
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_streak", 32'(dut.streak), 0);

    // Instruction-only read: BUSY x2 then ACCESS
    RST = 0; ramstate = BUSY; #1;
    chk("i_idle_ramREN", 32'(ramREN), 0);
    step();
    chk("i_grant_ramREN", 32'(ramREN), 1);
    chk("i_grant_addr", ramaddr, 32'h100);
    chk("i_busy_iwait", 32'(iwait), 1);
    step();
    chk("i_hold_ramREN", 32'(ramREN), 1);
    chk("i_hold_addr", ramaddr, 32'h100);
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("i_acc_iwait", 32'(iwait), 0);
    chk("i_acc_iload", iload, 32'hDEADBEEF);
    chk("i_acc_dwait", 32'(dwait), 1);
    step();
    iREN = 0; ramstate = FREE; #1;
    chk("i_after_ramREN", 32'(ramREN), 0);
    chk("i_after_iwait", 32'(iwait), 1);

    // Simultaneous requests: data first, bubble, then instruction
    iREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h5; ramstate = ACCESS; #1;
    chk("s_idle_dwait", 32'(dwait), 1);
    step();
    chk("s_d_ramWEN", 32'(ramWEN), 1);
    chk("s_d_ramREN", 32'(ramREN), 0);
    chk("s_d_addr", ramaddr, 32'h200);
    chk("s_d_store", ramstore, 32'h5);
    chk("s_d_dwait", 32'(dwait), 0);
    chk("s_d_iwait", 32'(iwait), 1);
    chk("s_d_streak", 32'(dut.streak), 1);
    step();
    dWEN = 0; #1;
    chk("s_bubble_ramWEN", 32'(ramWEN), 0);
    chk("s_bubble_addr", ramaddr, 0);
    step();
    chk("s_i_ramREN", 32'(ramREN), 1);
    chk("s_i_addr", ramaddr, 32'h100);
    chk("s_i_iwait", 32'(iwait), 0);
    chk("s_i_streak", 32'(dut.streak), 0);
    step();
    iREN = 0;

    // Read/write conflict, then RAM error and re-issue
    dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hA5; ramstate = BUSY;
    step();
    chk("rw_ramWEN", 32'(ramWEN), 1);
    chk("rw_ramREN", 32'(ramREN), 0);
    chk("rw_addr", ramaddr, 32'h300);
    chk("rw_store", ramstore, 32'hA5);
    ramstate = ERROR; #1;
    chk("e_err", 32'(err), 1);
    chk("e_dwait", 32'(dwait), 1);
    step();
    chk("e_next_err", 32'(err), 0);
    chk("e_next_ramWEN", 32'(ramWEN), 0);
    dWEN = 0; ramstate = ACCESS; #1;
    step();
    chk("e_retry_ramREN", 32'(ramREN), 1);
    chk("e_retry_addr", ramaddr, 32'h300);
    chk("e_retry_dwait", 32'(dwait), 0);
    step();
    dREN = 0;

    // Withdrawn request: back to IDLE without err
    iREN = 1; ramstate = BUSY;
    step();
    chk("w_grant_ramREN", 32'(ramREN), 1);
    iREN = 0; ramstate = ERROR; #1;
    chk("w_err", 32'(err), 0);
    step();
    chk("w_idle_ramREN", 32'(ramREN), 0);

    // Starvation guard: 4 data grants then 1 instruction grant, repeating
    dREN = 1; iREN = 1; daddr = 32'h400; iaddr = 32'h100; ramstate = ACCESS; #1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("starve_%0d", k), grant_code(), 32'(exp_seq[k]));
      step();
    end

    // Reset mid-transfer in IGRANT with BUSY
    dREN = 0; ramstate = BUSY; #1;
    chk("r_idle_ramREN", 32'(ramREN), 0);
    step();
    chk("r_grant_ramREN", 32'(ramREN), 1);
    RST = 1; #1;
    chk("r_rst_ramREN", 32'(ramREN), 0);
    chk("r_rst_addr", ramaddr, 0);
    chk("r_rst_iwait", 32'(iwait), 1);
    ramstate = ERROR; #1;
    chk("r_rst_err", 32'(err), 0);
    step();
    chk("r_state", 32'(dut.state), 0);
    chk("r_streak", 32'(dut.streak), 0);
    RST = 0; ramstate = BUSY; #1;
    chk("r_post_ramREN", 32'(ramREN), 0);
    chk("r_post_err", 32'(err), 0);
    step();
    chk("r_regrant_ramREN", 32'(ramREN), 1);
    chk("r_regrant_addr", ramaddr, 32'h100);
    iREN = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
